ibex_wb_arbiter: RTL and testbench

IBEX_WB_ARBITER -- requirements
Module: ibex_wb_arbiter

---
 rtl/ibex_wb_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ibex_wb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_arbiter.sv
// -----------------------------------------------------------------------------
// ibex_wb_arbiter
//
// Merges the Ibex instruction-fetch port and the load/store data port onto a
// single Wishbone B4 pipelined master. Requests are selected combinationally,
// issued when the bus is not stalled and the outstanding limit is not reached,
// and responses are routed back to the originating port using an in-order
// FIFO of 1-bit source IDs (0 = instruction, 1 = data).
//
// Parameters
//   MaxOutstanding : 1..8, number of issued-but-unanswered Wishbone requests
//   RoundRobin     : 1 = alternate on contention, 0 = data port always wins
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   instr_req_i/addr_i        : fetch request (held until granted)
//   instr_gnt_o               : fetch accepted this cycle
//   instr_rvalid_o/rdata_o/err_o : fetch response
//   data_req_i/we_i/be_i/addr_i/wdata_i : load/store request
//   data_gnt_o                : load/store accepted this cycle
//   data_rvalid_o/rdata_o/err_o  : load/store response
//   wb_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o : Wishbone master request side
//   wb_dat_i/ack_i/err_i/stall_i          : Wishbone master response side
// -----------------------------------------------------------------------------
module ibex_wb_arbiter #(
   parameter int unsigned MaxOutstanding = 4,
   parameter bit          RoundRobin     = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,

   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,

   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_stall_i
);

   // Count must represent 0..MaxOutstanding inclusive.
   localparam int unsigned CW = $clog2(MaxOutstanding + 1);
   // Pointer width kept at least one bit so MaxOutstanding = 1 still elaborates.
   localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   localparam logic [CW-1:0] MAX_CNT  = CW'(MaxOutstanding);
   localparam logic [PW-1:0] LAST_PTR = PW'(MaxOutstanding - 1);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic          r_prio_data;     // 1: data wins the next contention
   logic          r_id [MaxOutstanding];

   logic [CW-1:0] w_count_next;
   logic [PW-1:0] w_wr_ptr_next;
   logic [PW-1:0] w_rd_ptr_next;

   logic          w_any_req;
   logic          w_sel_data;
   logic          w_not_full;
   logic          w_stb;
   logic          w_issue;
   logic          w_resp;
   logic          w_head_data;

   // --------------------------------------------------------------------------
   // Request selection
   // --------------------------------------------------------------------------
   assign w_any_req = instr_req_i | data_req_i;

   // Data is selected when it is the only requester, or on contention when
   // fixed priority is in force or the round-robin flag currently favours it.
   assign w_sel_data = data_req_i &
                       (~instr_req_i | (RoundRobin == 1'b0) | r_prio_data);

   // The limit is checked against the registered count only, so a response
   // arriving while full does not open a slot until the following cycle.
   assign w_not_full = (r_count < MAX_CNT);

   // Strobe is forced low while reset is held so no request leaks out.
   assign w_stb   = w_any_req & w_not_full & rst_n;
   assign w_issue = w_stb & ~wb_stall_i;
   assign w_resp  = (wb_ack_i | wb_err_i) & (r_count != '0);

   always_comb begin
      wb_we_o  = 1'b0;
      wb_adr_o = instr_addr_i;
      wb_sel_o = 4'hF;
      wb_dat_o = 32'h0;
      if (w_sel_data) begin
         wb_we_o  = data_we_i;
         wb_adr_o = data_addr_i;
         wb_sel_o = data_be_i;
         wb_dat_o = data_wdata_i;
      end
   end

   assign wb_stb_o = w_stb;
   assign wb_cyc_o = w_stb | (r_count != '0);

   assign instr_gnt_o = w_issue & ~w_sel_data;
   assign data_gnt_o  = w_issue &  w_sel_data;

   // --------------------------------------------------------------------------
   // Response routing
   // --------------------------------------------------------------------------
   assign w_head_data = r_id[r_rd_ptr];

   assign instr_rvalid_o = w_resp & ~w_head_data;
   assign data_rvalid_o  = w_resp &  w_head_data;
   assign instr_err_o    = instr_rvalid_o & wb_err_i;
   assign data_err_o     = data_rvalid_o  & wb_err_i;
   assign instr_rdata_o  = wb_dat_i;
   assign data_rdata_o   = wb_dat_i;

   // --------------------------------------------------------------------------
   // ID FIFO bookkeeping
   // --------------------------------------------------------------------------
   always_comb begin
      w_count_next  = r_count;
      w_wr_ptr_next = r_wr_ptr;
      w_rd_ptr_next = r_rd_ptr;

      // Pop and push in the same cycle leave the count unchanged.
      case ({w_issue, w_resp})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase

      if (w_issue) begin
         w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_resp) begin
         w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_prio_data <= 1'b1;
      end else begin
         r_count  <= w_count_next;
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
         // Flag moves only on an accepted request; stalled cycles keep it.
         if (w_issue) begin
            r_prio_data <= ~w_sel_data;
         end
      end
   end

   // One storage slot per outstanding request; written only when the write
   // pointer addresses it during an issue.
   genvar gi;
   generate
      for (gi = 0; gi < MaxOutstanding; gi++) begin : g_slot
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_id[gi] <= 1'b0;
            end else if (w_issue && (r_wr_ptr == PW'(gi))) begin
               r_id[gi] <= w_sel_data;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ibex_wb_arbiter
//
// Directed bench for ibex_wb_arbiter. Two instances share all inputs: u_dut
// uses round-robin arbitration, u_dut0 fixed data priority (only inspected in
// the contention step). Inputs change 1 time unit after a rising edge and
// outputs are checked 2 units later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_ibex_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_stall_i;

   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;

   logic        d0_instr_gnt, d0_instr_rvalid, d0_instr_err;
   logic [31:0] d0_instr_rdata;
   logic        d0_data_gnt, d0_data_rvalid, d0_data_err;
   logic [31:0] d0_data_rdata;
   logic        d0_cyc, d0_stb, d0_we;
   logic [31:0] d0_adr, d0_dat;
   logic [3:0]  d0_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibex_wb_arbiter #(.MaxOutstanding(4), .RoundRobin(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .wb_stall_i(wb_stall_i)
   );

   ibex_wb_arbiter #(.MaxOutstanding(4), .RoundRobin(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(d0_instr_gnt), .instr_rvalid_o(d0_instr_rvalid),
      .instr_rdata_o(d0_instr_rdata), .instr_err_o(d0_instr_err),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(d0_data_gnt), .data_rvalid_o(d0_data_rvalid),
      .data_rdata_o(d0_data_rdata), .data_err_o(d0_data_err),
      .wb_cyc_o(d0_cyc), .wb_stb_o(d0_stb), .wb_we_o(d0_we),
      .wb_adr_o(d0_adr), .wb_sel_o(d0_sel), .wb_dat_o(d0_dat),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .wb_stall_i(wb_stall_i)
   );

   // One line per bus transaction of the round-robin instance.
   always @(negedge clk) begin
      if (instr_gnt_o)    $display("txn t=%0t issue instr adr=%h", $time, wb_adr_o);
      if (data_gnt_o)     $display("txn t=%0t issue data  adr=%h we=%0d sel=%h", $time, wb_adr_o, wb_we_o, wb_sel_o);
      if (instr_rvalid_o) $display("txn t=%0t resp  instr rdata=%h err=%0d", $time, instr_rdata_o, instr_err_o);
      if (data_rvalid_o)  $display("txn t=%0t resp  data  rdata=%h err=%0d", $time, data_rdata_o, data_err_o);
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // ---- reset held with both ports requesting ----
      rst_n = 1'b0;
      instr_req_i = 1'b1; instr_addr_i = 32'h0;
      data_req_i = 1'b1;  data_we_i = 1'b0; data_be_i = 4'hF;
      data_addr_i = 32'h0; data_wdata_i = 32'h0;
      wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
      #2;
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_igrant", instr_gnt_o, 0);
      chk("rst_dgrant", data_gnt_o, 0);
      chk("rst_irvalid", instr_rvalid_o, 0);
      chk("rst_drvalid", data_rvalid_o, 0);
      tick();
      rst_n = 1'b1;
      instr_req_i = 1'b0;

      // ---- single data write ----
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
      data_addr_i = 32'h100; data_wdata_i = 32'hDEADBEEF;
      #2;
      chk("wr_stb", wb_stb_o, 1);
      chk("wr_cyc", wb_cyc_o, 1);
      chk("wr_sel", wb_sel_o, 4'b0011);
      chk("wr_we", wb_we_o, 1);
      chk("wr_adr", wb_adr_o, 32'h100);
      chk("wr_dat", wb_dat_o, 32'hDEADBEEF);
      chk("wr_dgnt", data_gnt_o, 1);
      chk("wr_ignt", instr_gnt_o, 0);
      tick();
      data_req_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
      #2;
      chk("wr_drvalid", data_rvalid_o, 1);
      chk("wr_irvalid", instr_rvalid_o, 0);
      chk("wr_derr", data_err_o, 0);
      chk("wr_cyc_resp", wb_cyc_o, 1);
      chk("wr_stb_idle", wb_stb_o, 0);
      tick();
      wb_ack_i = 1'b0;
      #2;
      chk("wr_drvalid_once", data_rvalid_o, 0);
      chk("wr_cyc_drop", wb_cyc_o, 0);

      // ---- contention: RR alternates D,I,D,I; fixed priority always D ----
      tick();
      do_reset();
      instr_req_i = 1'b1; instr_addr_i = 32'h200;
      data_req_i = 1'b1;  data_addr_i = 32'h300; data_we_i = 1'b0; data_be_i = 4'hF;
      for (int k = 0; k < 4; k++) begin
         logic exp_d;
         exp_d = (k % 2 == 0);
         wb_ack_i = (k != 0);
         wb_dat_i = 32'hA000_0000 + k;
         #2;
         chk($sformatf("rr_dgnt%0d", k), data_gnt_o, exp_d);
         chk($sformatf("rr_ignt%0d", k), instr_gnt_o, !exp_d);
         chk($sformatf("rr_adr%0d", k), wb_adr_o, exp_d ? 32'h300 : 32'h200);
         if (k != 0) begin
            chk($sformatf("rr_drv%0d", k), data_rvalid_o, (k % 2 == 1));
            chk($sformatf("rr_irv%0d", k), instr_rvalid_o, (k % 2 == 0));
         end
         chk($sformatf("fp_dgnt%0d", k), d0_data_gnt, 1);
         chk($sformatf("fp_ignt%0d", k), d0_instr_gnt, 0);
         tick();
      end
      instr_req_i = 1'b0; data_req_i = 1'b0; wb_ack_i = 1'b1;
      #2;
      chk("rr_irv_last", instr_rvalid_o, 1);
      chk("rr_drv_last", data_rvalid_o, 0);
      chk("fp_drv_last", d0_data_rvalid, 1);
      tick();
      wb_ack_i = 1'b0;
      #2;
      chk("rr_cyc_drop", wb_cyc_o, 0);

      // ---- stall for three cycles, then error response on the fetch ----
      instr_req_i = 1'b1; instr_addr_i = 32'h80; wb_stall_i = 1'b1;
      for (int s = 0; s < 3; s++) begin
         #2;
         chk($sformatf("stall_stb%0d", s), wb_stb_o, 1);
         chk($sformatf("stall_adr%0d", s), wb_adr_o, 32'h80);
         chk($sformatf("stall_ignt%0d", s), instr_gnt_o, 0);
         tick();
      end
      wb_stall_i = 1'b0;
      #2;
      chk("stall_release_gnt", instr_gnt_o, 1);
      tick();
      instr_req_i = 1'b0; wb_err_i = 1'b1;
      #2;
      chk("err_irvalid", instr_rvalid_o, 1);
      chk("err_ierr", instr_err_o, 1);
      chk("err_drvalid", data_rvalid_o, 0);
      chk("err_derr", data_err_o, 0);
      tick();
      wb_err_i = 1'b0;

      // ---- outstanding limit ----
      do_reset();
      instr_req_i = 1'b1; instr_addr_i = 32'h400;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk($sformatf("full_gnt%0d", k), instr_gnt_o, 1);
         tick();
      end
      #2;
      chk("full_stb", wb_stb_o, 0);
      chk("full_cyc", wb_cyc_o, 1);
      chk("full_gnt", instr_gnt_o, 0);
      tick();
      wb_ack_i = 1'b1;
      #2;
      chk("full_ack_stb", wb_stb_o, 0);
      chk("full_ack_gnt", instr_gnt_o, 0);
      chk("full_ack_irv", instr_rvalid_o, 1);
      tick();
      wb_ack_i = 1'b0;
      #2;
      chk("full_refill_stb", wb_stb_o, 1);
      chk("full_refill_gnt", instr_gnt_o, 1);
      tick();
      instr_req_i = 1'b0; wb_ack_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk($sformatf("drain_irv%0d", k), instr_rvalid_o, 1);
         tick();
      end
      wb_ack_i = 1'b0;
      #2;
      chk("drain_cyc", wb_cyc_o, 0);

      // ---- stray ack with nothing outstanding, then a normal load ----
      tick();
      wb_ack_i = 1'b1;
      #2;
      chk("stray_irv", instr_rvalid_o, 0);
      chk("stray_drv", data_rvalid_o, 0);
      chk("stray_cyc", wb_cyc_o, 0);
      tick();
      wb_ack_i = 1'b0;
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h500;
      #2;
      chk("ld_gnt", data_gnt_o, 1);
      chk("ld_we", wb_we_o, 0);
      tick();
      data_req_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
      #2;
      chk("ld_drv", data_rvalid_o, 1);
      chk("ld_drdata", data_rdata_o, 32'hCAFEF00D);
      chk("ld_irdata", instr_rdata_o, 32'hCAFEF00D);
      tick();
      wb_ack_i = 1'b0;
      #2;
      chk("ld_drv_once", data_rvalid_o, 0);
      chk("ld_cyc_drop", wb_cyc_o, 0);

      // ---- reset with two outstanding fetches ----
      instr_req_i = 1'b1; instr_addr_i = 32'h600;
      #2;
      chk("rmid_gnt0", instr_gnt_o, 1);
      tick();
      #2;
      chk("rmid_gnt1", instr_gnt_o, 1);
      tick();
      rst_n = 1'b0; wb_ack_i = 1'b1;
      #1;
      chk("rmid_cyc", wb_cyc_o, 0);
      chk("rmid_stb", wb_stb_o, 0);
      chk("rmid_ignt", instr_gnt_o, 0);
      chk("rmid_irv", instr_rvalid_o, 0);
      chk("rmid_drv", data_rvalid_o, 0);
      rst_n = 1'b1; instr_req_i = 1'b0;
      #1;
      chk("rpost_irv", instr_rvalid_o, 0);
      chk("rpost_cyc", wb_cyc_o, 0);
      tick();
      #1;
      chk("rpost_irv2", instr_rvalid_o, 0);
      chk("rpost_drv2", data_rvalid_o, 0);
      wb_ack_i = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
